pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port BR, input, 1: current instruction is a conditional branch (bne/blt), from the control decoder.
REQ-004 SHALL have port JP, input, 1: current instruction is an unconditional jump (j), from the control decoder.
REQ-005 SHALL have port take_br, input, 1: ALU compare outcome, already selected per branch type.
REQ-006 SHALL have port imm, input, 17: signed branch offset, in words.
REQ-007 SHALL have port target, input, 27: jump target; only bits [11:0] are used.
REQ-008 SHALL have port imem_ready, input, 1: instruction memory accepts the address on pc this cycle.
REQ-009 SHALL have port stall, input, 1: downstream hold request.
REQ-010 SHALL have port pc, output, 12: current fetch address.
REQ-011 SHALL have port pc_plus1, output, 12: pc+1 mod 4096, combinational from pc.
REQ-012 SHALL have port fetch_valid, output, 1: pc is a valid fetch request.
REQ-013 SHALL have port redirect, output, 1: one-cycle pulse on the cycle after a taken branch or jump is accepted.

Function
REQ-014 SHALL implement the states IDLE, RUN and BUBBLE, with fetch_valid=1 only in RUN.
REQ-015 SHALL define accept = fetch_valid & imem_ready & ~stall; BR/JP/take_br/imm/target are sampled only on accept edges.
REQ-016 SHALL use the following next-PC rules on accept, in priority order: JP -> target[11:0]; BR&take_br -> pc+1+sext(imm), truncated to 12 bits; otherwise pc+1.
REQ-017 SHALL wrap all PC arithmetic modulo 4096 (4095+1=0; 0+1-2=4095) with no error flag.
REQ-018 SHALL ignore BR when JP=1 (JP wins); BR with take_br=0 SHALL advance sequentially.
REQ-019 SHALL hold pc and all outputs unchanged without accept (the stall/not-ready cycles), and SHALL discard decode inputs in those cycles.
REQ-020 SHALL make the transitions IDLE->RUN unconditionally on the first edge after reset release; RUN->BUBBLE on a redirecting accept (with macro, REQ-026); BUBBLE->RUN after exactly one cycle, regardless of stall.
REQ-021 SHALL give a latency of one edge from accept to the new pc value; redirect is asserted in that same following cycle only.
REQ-022 SHALL, when stall and imem_ready rise simultaneously, not accept; stall has priority.

Reset
REQ-023 SHALL on reset drive pc=0, state=IDLE, fetch_valid=0 and redirect=0 immediately (asynchronously); pc_plus1=1.
REQ-024 SHALL abandon an in-flight redirect or bubble on reset mid-operation; after release, fetch resumes at 0 via IDLE.
REQ-025 SHALL have no input effect during reset; the first possible accept is the second edge after release.

Configuration
REQ-026 SHALL, when macro PC_SEQ_BRANCH_BUBBLE_EN is defined, enter BUBBLE for one cycle after every redirecting accept (fetch_valid=0, pc already at the new target).
REQ-027 SHALL, when PC_SEQ_BRANCH_BUBBLE_EN is undefined, remove BUBBLE entirely; redirecting accepts stay in RUN with fetch_valid=1 continuously, and redirect still pulses.

Structure
REQ-028 SHALL take from shared package pc_seq_pkg: PC_W=12, IMM_W=17, TGT_W=27, and the state enumeration typedef.
REQ-029 SHALL instantiate one sub-module, pc_next_calc (combinational), computing the pc+1, branch-target and jump-target mux; the FSM and PC register remain in pc_sequencer.

Verification
REQ-030 SHALL cover: reset release, imem_ready=1, stall=0, BR=JP=0 -> fetch_valid=0 for one cycle, then pc=0,1,2,3 on successive cycles.
REQ-031 SHALL cover: pc=10, BR=1, take_br=1, imm=-3 accepted -> pc=8 next cycle, redirect=1 for one cycle; with macro, fetch_valid=0 for that cycle.
REQ-032 SHALL cover: pc=20, JP=1 and BR=1, take_br=1, imm=5, target=0x0000123 -> pc=0x123 (jump wins).
REQ-033 SHALL cover: pc=4095 sequential -> pc=0; pc=2, BR=1, take_br=1, imm=-4 -> pc=4095.
REQ-034 SHALL cover: pc=7, stall=1 for 3 cycles with JP=1, target=50 -> pc stays 7 with no redirect; on stall=0 with JP=1 -> pc=50.
REQ-035 SHALL cover: reset asserted in the redirect cycle (pc=8) -> pc=0, fetch_valid=0, redirect=0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: widths, FSM state type and the
// redirect decision used by both the next-PC mux and the FSM.
package pc_seq_pkg;

  localparam int PC_W  = 12;
  localparam int IMM_W = 17;
  localparam int TGT_W = 27;

  // state  | meaning
  // IDLE   | out of reset, no fetch request yet
  // RUN    | fetch_valid=1, pc is presented to instruction memory
  // BUBBLE | one dead cycle after a redirect (bubble builds only)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } pc_state_t;

  // A jump always redirects; a branch redirects only when the compare is taken.
  function automatic logic is_redirect(input logic br, input logic jp, input logic take_br);
    return jp | (br & take_br);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential pc+1, branch target
// pc+1+sext(imm) and jump target, all wrapped modulo 2**PC_W.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_br,
  input  logic             i_jp,
  input  logic             i_take_br,
  input  logic [IMM_W-1:0] i_imm,
  input  logic [TGT_W-1:0] i_target,
  output logic [PC_W-1:0]  o_pc_plus1,
  output logic [PC_W-1:0]  o_pc_next,
  output logic             o_redirect
);

  logic [PC_W-1:0] w_plus1;
  logic [PC_W-1:0] w_br_tgt;
  logic [PC_W-1:0] w_jp_tgt;
  logic            w_br_taken;
  logic            w_unused;

  assign w_plus1    = i_pc + PC_W'(1);
  // Upper offset bits only carry sign extension, which vanishes modulo 2**PC_W.
  assign w_br_tgt   = w_plus1 + i_imm[PC_W-1:0];
  assign w_jp_tgt   = i_target[PC_W-1:0];
  assign w_br_taken = i_br & i_take_br;
  assign w_unused   = ^{i_imm[IMM_W-1:PC_W], i_target[TGT_W-1:PC_W]};

  assign o_pc_plus1 = w_plus1;
  assign o_redirect = is_redirect(i_br, i_jp, i_take_br);

  // Priority mux: jump beats a taken branch, otherwise fall through.
  always_comb begin
    o_pc_next = w_plus1;
    if (i_jp) begin
      o_pc_next = w_jp_tgt;
    end else if (w_br_taken) begin
      o_pc_next = w_br_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch-address register and fetch FSM.
// Build option: define PC_SEQ_BRANCH_BUBBLE_EN to insert one dead fetch
// cycle (BUBBLE) after every taken branch or jump; without it the FSM
// stays in RUN across redirects.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             BR,
  input  logic             JP,
  input  logic             take_br,
  input  logic [IMM_W-1:0] imm,
  input  logic [TGT_W-1:0] target,
  input  logic             imem_ready,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             fetch_valid,
  output logic             redirect
);

  pc_state_t       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_redirect;

  logic            w_accept;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_plus1;
  logic            w_redirect;

  // Stall overrides a ready memory; decode inputs only matter on accept.
  assign w_accept = r_fetch_valid & imem_ready & ~stall;

  pc_next_calc u_next (
    .i_pc       (r_pc),
    .i_br       (BR),
    .i_jp       (JP),
    .i_take_br  (take_br),
    .i_imm      (imm),
    .i_target   (target),
    .o_pc_plus1 (w_pc_plus1),
    .o_pc_next  (w_pc_next),
    .o_redirect (w_redirect)
  );

  // Fetch FSM with PC register; redirect is a single-cycle pulse after a redirecting accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_fetch_valid <= 1'b0;
      r_redirect    <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (w_accept) begin
            r_pc       <= w_pc_next;
            r_redirect <= w_redirect;
`ifdef PC_SEQ_BRANCH_BUBBLE_EN
            if (w_redirect) begin
              r_state       <= ST_BUBBLE;
              r_fetch_valid <= 1'b0;
            end
`endif
          end
        end
`ifdef PC_SEQ_BRANCH_BUBBLE_EN
        ST_BUBBLE: begin
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
`endif
        default: begin
          r_state       <= ST_IDLE;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus1    = w_pc_plus1;
  assign fetch_valid = r_fetch_valid;
  assign redirect    = r_redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a random
// run checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_BRANCH_BUBBLE_EN
  localparam bit BUBBLE_EN = 1'b1;
`else
  localparam bit BUBBLE_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             BR = 1'b0;
  logic             JP = 1'b0;
  logic             take_br = 1'b0;
  logic [IMM_W-1:0] imm = '0;
  logic [TGT_W-1:0] target = '0;
  logic             imem_ready = 1'b0;
  logic             stall = 1'b0;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus1;
  logic             fetch_valid;
  logic             redirect;

  int n_vec = 0;
  int n_err = 0;

  // Model state: fetch address, whether fetching has begun since reset,
  // whether a dead cycle is owed, and the visible valid/redirect flags.
  int m_pc      = 0;
  bit m_started = 1'b0;
  bit m_bubble  = 1'b0;
  bit m_fv      = 1'b0;
  bit m_red     = 1'b0;

  pc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .BR          (BR),
    .JP          (JP),
    .take_br     (take_br),
    .imm         (imm),
    .target      (target),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
    .redirect    (redirect)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_next(input int cur, input logic br, input logic jp,
                                    input logic tk, input logic [IMM_W-1:0] im,
                                    input logic [TGT_W-1:0] tg);
    int off;
    if (jp) return int'(tg) % 4096;
    if (br && tk) begin
      off = int'($signed(im));
      return (((cur + 1 + off) % 4096) + 4096) % 4096;
    end
    return (cur + 1) % 4096;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_started = 1'b0; m_bubble = 1'b0; m_fv = 1'b0; m_red = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, return #1 after the edge.
  task automatic drive_cycle(input logic br, input logic jp, input logic tk,
                             input logic [IMM_W-1:0] im, input logic [TGT_W-1:0] tg,
                             input logic rdy, input logic stl);
    int npc;
    bit nfv, nred, nbub, take;
    BR = br; JP = jp; take_br = tk; imm = im; target = tg;
    imem_ready = rdy; stall = stl;
    npc = m_pc; nfv = m_fv; nred = 1'b0; nbub = 1'b0;
    take = jp || (br && tk);
    if (!m_started || m_bubble) begin
      nfv = 1'b1;
    end else if (m_fv && rdy && !stl) begin
      npc  = model_next(m_pc, br, jp, tk, im, tg);
      nred = take;
      if (BUBBLE_EN && take) begin nbub = 1'b1; nfv = 1'b0; end
    end
    @(posedge clock);
    #1;
    m_pc = npc; m_fv = nfv; m_red = nred; m_bubble = nbub; m_started = 1'b1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Jump to x, then one not-ready cycle so any bubble has drained.
  task automatic goto_pc(input int x);
    drive_cycle(1'b0, 1'b1, 1'b0, '0, TGT_W'(x), 1'b1, 1'b0);
    idle_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    n_vec++;
    if (pc !== 12'd0 || fetch_valid !== 1'b0 || redirect !== 1'b0 || pc_plus1 !== 12'd1) begin
      n_err++;
      $display("FAIL reset_values: pc=%0d fv=%0b red=%0b pc_plus1=%0d, want 0/0/0/1",
               pc, fetch_valid, redirect, pc_plus1);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1; stall = 1'b0;
    n_vec++;
    if (fetch_valid !== 1'b0) begin
      n_err++; $display("FAIL seq_first_cycle: fv=%0b want 0", fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      n_vec++;
      if (pc !== 12'(i) || fetch_valid !== 1'b1 || redirect !== 1'b0) begin
        n_err++;
        $display("FAIL seq_step%0d: pc=%0d fv=%0b red=%0b, want %0d/1/0", i, pc, fetch_valid, redirect, i);
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(10);
    drive_cycle(1'b1, 1'b0, 1'b1, IMM_W'(-3), '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd8 || redirect !== 1'b1 || fetch_valid !== !BUBBLE_EN) begin
      n_err++;
      $display("FAIL branch_back: pc=%0d red=%0b fv=%0b, want 8/1/%0b", pc, redirect, fetch_valid, !BUBBLE_EN);
    end
    idle_cycle();
    n_vec++;
    if (pc !== 12'd8 || redirect !== 1'b0 || fetch_valid !== 1'b1) begin
      n_err++;
      $display("FAIL branch_after: pc=%0d red=%0b fv=%0b, want 8/0/1", pc, redirect, fetch_valid);
    end
  endtask

  task automatic test_jump_priority();
    goto_pc(20);
    drive_cycle(1'b1, 1'b1, 1'b1, IMM_W'(5), TGT_W'('h0000123), 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'h123 || redirect !== 1'b1) begin
      n_err++; $display("FAIL jump_wins: pc=%0h red=%0b, want 123/1", pc, redirect);
    end
  endtask

  task automatic test_wrap();
    goto_pc(4095);
    n_vec++;
    if (pc_plus1 !== 12'd0) begin
      n_err++; $display("FAIL wrap_plus1: pc_plus1=%0d want 0", pc_plus1);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd0 || redirect !== 1'b0) begin
      n_err++; $display("FAIL wrap_seq: pc=%0d red=%0b, want 0/0", pc, redirect);
    end
    goto_pc(2);
    drive_cycle(1'b1, 1'b0, 1'b1, IMM_W'(-4), '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd4095 || redirect !== 1'b1) begin
      n_err++; $display("FAIL wrap_branch: pc=%0d red=%0b, want 4095/1", pc, redirect);
    end
  endtask

  task automatic test_branch_not_taken();
    goto_pc(30);
    drive_cycle(1'b1, 1'b0, 1'b0, IMM_W'(100), '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd31 || redirect !== 1'b0 || fetch_valid !== 1'b1) begin
      n_err++;
      $display("FAIL branch_nt: pc=%0d red=%0b fv=%0b, want 31/0/1", pc, redirect, fetch_valid);
    end
  endtask

  task automatic test_stall();
    goto_pc(7);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, '0, TGT_W'(50), 1'b1, 1'b1);
      n_vec++;
      if (pc !== 12'd7 || redirect !== 1'b0 || fetch_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d: pc=%0d red=%0b fv=%0b, want 7/0/1", i, pc, redirect, fetch_valid);
      end
    end
    drive_cycle(1'b0, 1'b1, 1'b0, '0, TGT_W'(50), 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd50 || redirect !== 1'b1) begin
      n_err++; $display("FAIL stall_release: pc=%0d red=%0b, want 50/1", pc, redirect);
    end
  endtask

  task automatic test_reset_mid();
    goto_pc(10);
    drive_cycle(1'b1, 1'b0, 1'b1, IMM_W'(-3), '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd8 || redirect !== 1'b1) begin
      n_err++; $display("FAIL rstmid_setup: pc=%0d red=%0b, want 8/1", pc, redirect);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (pc !== 12'd0 || fetch_valid !== 1'b0 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: pc=%0d fv=%0b red=%0b, want 0/0/0", pc, fetch_valid, redirect);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b0, '0, TGT_W'(77), 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd0 || fetch_valid !== 1'b1 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_idle: pc=%0d fv=%0b red=%0b, want 0/1/0", pc, fetch_valid, redirect);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_vec++;
    if (pc !== 12'd1) begin
      n_err++; $display("FAIL rstmid_resume: pc=%0d want 1", pc);
    end
  endtask

  task automatic test_random();
    logic br, jp, tk, rdy, stl;
    logic [IMM_W-1:0] im;
    logic [TGT_W-1:0] tg;
    for (int i = 0; i < 300; i++) begin
      br  = ($urandom_range(0, 2) == 0);
      jp  = ($urandom_range(0, 5) == 0);
      tk  = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      im  = ($urandom_range(0, 1) == 1) ? IMM_W'($urandom) : IMM_W'(int'($urandom_range(0, 16)) - 8);
      tg  = TGT_W'($urandom);
      drive_cycle(br, jp, tk, im, tg, rdy, stl);
      n_vec++;
      if (pc !== 12'(m_pc) || fetch_valid !== m_fv || redirect !== m_red ||
          pc_plus1 !== 12'((m_pc + 1) % 4096)) begin
        n_err++;
        $display("FAIL random%0d: pc=%0d fv=%0b red=%0b p1=%0d, want %0d/%0b/%0b/%0d",
                 i, pc, fetch_valid, redirect, pc_plus1, m_pc, m_fv, m_red, (m_pc + 1) % 4096);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_branch_not_taken();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
